// File: rtl/led_pattern_gen_if.sv
// Control and LED-drive bundle for led_pattern_gen.
// The master side is the control logic and the slave side is the pattern generator.
interface led_pattern_gen_if #(
  parameter int LED_W   = 4,
  parameter int PRESC_W = 24
);
  logic [1:0]         mode;
  logic [PRESC_W-1:0] period;
  logic [LED_W-1:0]   pattern;
  logic               load;
  logic [LED_W-1:0]   led;
  logic               tick;

  modport master (
    output mode, period, pattern, load,
    input  led, tick
  );

  modport slave (
    input  mode, period, pattern, load,
    output led, tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Programmable LED pattern generator: static, blink, rotate and bounce modes paced by a prescaler.
// Define LED_PATTERN_GEN_ACTIVE_LOW_EN to drive the led port inverted for active-low board wiring.
module led_pattern_gen #(
  parameter int LED_W   = 4,
  parameter int PRESC_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  led_pattern_gen_if.slave bus
);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

  function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v);
    logic [LED_W-1:0] r;
    r = '0;
    for (int i = 0; i < LED_W; i++) begin
      r[(i + 1) % LED_W] = v[i];
    end
    return r;
  endfunction

  logic [PRESC_W-1:0] cnt_q,   cnt_d;
  logic [1:0]         mode_q,  mode_d;
  logic               phase_q, phase_d;
  logic               dir_q,   dir_d;
  logic [LED_W-1:0]   led_q,   led_d;
  // Forces the first edge after reset to behave as a restart even when mode is still 0.
  logic               init_q,  init_d;

  logic restart;
  logic step_due;
  logic step;
  logic led_one_hot;

  assign restart     = bus.load || (bus.mode != mode_q) || init_q;
  assign step_due    = (cnt_q >= bus.period);
  assign step        = step_due && !restart;
  assign led_one_hot = (led_q != '0) && ((led_q & (led_q - LED_ONE)) == '0);

  // Combinational from reset so tick drops the instant rst rises, not at the next edge.
  assign bus.tick = step && !rst;

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = bus.mode;
    phase_d = phase_q;
    dir_d   = dir_q;
    led_d   = led_q;
    init_d  = 1'b0;

    if (restart || step_due) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end

    if (restart) begin
      unique case (bus.mode)
        MODE_STATIC: led_d = bus.pattern;
        MODE_BLINK: begin
          phase_d = 1'b1;
          led_d   = bus.pattern;
        end
        MODE_ROTATE: led_d = bus.pattern;
        MODE_BOUNCE: begin
          led_d = LED_ONE;
          dir_d = DIR_UP;
        end
        default: led_d = bus.pattern;
      endcase
    end else begin
      unique case (bus.mode)
        MODE_STATIC: led_d = bus.pattern;

        // Led follows pattern through the whole on-phase and goes dark for the off-phase.
        MODE_BLINK: begin
          if (step) begin
            phase_d = !phase_q;
          end
          led_d = phase_d ? bus.pattern : '0;
        end

        MODE_ROTATE: begin
          if (step) begin
            led_d = rotl(led_q);
          end
        end

        MODE_BOUNCE: begin
          if (step) begin
            if (!led_one_hot) begin
              led_d = LED_ONE;
              dir_d = DIR_UP;
            end else if (LED_W == 1) begin
              led_d = LED_ONE;
            end else if (dir_q == DIR_UP) begin
              // Reverse at the end bit without dwelling there for an extra step.
              if (led_q[LED_W-1]) begin
                led_d = led_q >> 1;
                dir_d = DIR_DOWN;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;
                dir_d = DIR_UP;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
        end

        default: led_d = led_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      mode_q  <= MODE_STATIC;
      phase_q <= 1'b0;
      dir_q   <= DIR_UP;
      led_q   <= '0;
      init_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      init_q  <= init_d;
    end
  end

`ifdef LED_PATTERN_GEN_ACTIVE_LOW_EN
  assign bus.led = ~led_q;
`else
  assign bus.led = led_q;
`endif

endmodule
